// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   ld_state_t     : loader FSM states
//   INSTR_W        : instruction word width in bits
//   BYTES_PER_WORD : stream bytes packed into one instruction word
package imem_pkg;

   typedef enum logic [1:0] {LD_IDLE, LD_RECV, LD_WRITE, LD_DONE} ld_state_t;

   localparam int INSTR_W        = 32;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: 4-lane little-endian pack register with lane counter.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : empty all lanes and restart at lane 0 (wins over en)
//   en        : accept byte_in into the current lane
//   byte_in   : incoming stream byte
//   word_nxt  : current lanes with byte_in merged into the current lane,
//               i.e. the complete word when the last lane is being filled
//   last      : current lane is the final lane of the word
module byte_packer
   import imem_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [7:0]         byte_in,
   output logic [INSTR_W-1:0] word_nxt,
   output logic               last
);

   logic [INSTR_W-1:0] lanes_q, lanes_d;
   logic [1:0]         lane_cnt_q, lane_cnt_d;

   always_comb begin
      word_nxt = lanes_q;
      case (lane_cnt_q)
         2'd0:    word_nxt[7:0]   = byte_in;
         2'd1:    word_nxt[15:8]  = byte_in;
         2'd2:    word_nxt[23:16] = byte_in;
         default: word_nxt[31:24] = byte_in;
      endcase
      last = (lane_cnt_q == 2'(BYTES_PER_WORD - 1));

      lanes_d    = lanes_q;
      lane_cnt_d = lane_cnt_q;
      if (clr) begin
         lanes_d    = '0;
         lane_cnt_d = '0;
      end else if (en) begin
         lanes_d    = word_nxt;
         lane_cnt_d = lane_cnt_q + 2'd1;   // wraps to lane 0 after the last lane
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_q    <= '0;
         lane_cnt_q <= '0;
      end else begin
         lanes_q    <= lanes_d;
         lane_cnt_q <= lane_cnt_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory. Packs a little-endian
// byte stream into 32-bit words and writes them to consecutive word addresses
// while holding the fetch stage stalled.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : one-cycle pulse, begins a load (honoured in IDLE/DONE only)
//   load_len    : words to load, sampled with start; 0 = no-op
//   byte_in     : stream byte
//   byte_valid  : byte_in valid
//   byte_ready  : loader accepts a byte this cycle
//   wr_en       : instr_mem write strobe, one cycle per word
//   wr_addr     : word address of the write
//   wr_data     : packed word {b3,b2,b1,b0}, b0 = first byte received
//   cpu_stall   : high while loading
//   done        : high in DONE until the next start
//   err         : sticky inter-byte timeout flag, cleared by an accepted start
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W:0]    load_len,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               cpu_stall,
   output logic               done,
   output logic               err
);

   localparam int              TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [ADDR_W:0]  DEPTH    = {1'b1, {ADDR_W{1'b0}}};

   ld_state_t          state_q, state_d;
   logic [ADDR_W:0]    word_cnt_q, word_cnt_d;
   logic [ADDR_W:0]    len_q, len_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               byte_ready_q, byte_ready_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [INSTR_W-1:0] wr_data_q, wr_data_d;
   logic               cpu_stall_q, cpu_stall_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               pk_clr;
   logic [INSTR_W-1:0] pk_word;
   logic               pk_last;

   assign xfer   = byte_valid & byte_ready_q;
   // Lanes only hold data while receiving; this also discards a partial word on timeout.
   assign pk_clr = (state_q != LD_RECV);

   byte_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (pk_clr),
      .en       (xfer),
      .byte_in  (byte_in),
      .word_nxt (pk_word),
      .last     (pk_last)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      timer_d    = timer_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      err_d      = err_q;

      case (state_q)
         LD_IDLE, LD_DONE: begin
            if (start) begin
               err_d      = 1'b0;
               word_cnt_d = '0;
               timer_d    = '0;
               if (load_len == '0) begin
                  state_d = LD_DONE;
               end else begin
                  state_d = LD_RECV;
                  // Clamp so wr_addr never wraps past the top of memory.
                  len_d   = (load_len > DEPTH) ? DEPTH : load_len;
               end
            end
         end
         LD_RECV: begin
            if (xfer) begin
               timer_d = '0;
               if (pk_last) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = word_cnt_q[ADDR_W-1:0];
                  wr_data_d = pk_word;
                  state_d   = LD_WRITE;
               end
            end else if (timer_q == TMR_LAST) begin
               state_d = LD_DONE;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         LD_WRITE: begin
            word_cnt_d = word_cnt_q + 1'b1;
            timer_d    = '0;
            state_d    = (word_cnt_d == len_q) ? LD_DONE : LD_RECV;
         end
         default: state_d = LD_IDLE;
      endcase

      // Status outputs are registered views of the next state.
      byte_ready_d = (state_d == LD_RECV);
      cpu_stall_d  = (state_d == LD_RECV) || (state_d == LD_WRITE);
      done_d       = (state_d == LD_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LD_IDLE;
         word_cnt_q   <= '0;
         len_q        <= '0;
         timer_q      <= '0;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         cpu_stall_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         len_q        <= len_d;
         timer_q      <= timer_d;
         byte_ready_q <= byte_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         cpu_stall_q  <= cpu_stall_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign cpu_stall  = cpu_stall_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (small memory, short timeout). A transaction
// model turns every accepted byte into the expected memory write (address,
// packed word, cycle) and a compare process checks each write strobe.
module tb_imem_loader;

   localparam int AW = 2;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   load_len = '0;
   logic [7:0]    byte_in = '0;
   logic          byte_valid = 1'b0;
   logic          byte_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          cpu_stall;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .load_len   (load_len),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_stall  (cpu_stall),
      .done       (done),
      .err        (err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nwr = 0;
   logic [31:0]   last_data = '0;
   logic [AW-1:0] last_addr = '0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      int            cyc;
   } wr_t;
   wr_t exp_q[$];

   // Transaction model state
   int         m_limit = 0;
   int         m_words = 0;
   int         m_n = 0;
   logic [7:0] m_buf [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   // Every write strobe must match the oldest expected write, including its cycle.
   always @(negedge clk) begin
      if (!rst && wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", wr_addr, wr_data, cyc);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                        wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
            end
         end
         nwr++;
         last_data = wr_data;
         last_addr = wr_addr;
      end
      if (!rst) begin
         checks++;
         if ((byte_ready && !cpu_stall) || (done && cpu_stall) || (wr_en && byte_ready)) begin
            errors++;
            $display("FAIL status_combo ready=%b stall=%b done=%b wr_en=%b", byte_ready, cpu_stall, done, wr_en);
         end
      end
   end

   task automatic model_start(input int len);
      m_limit = (len > (1 << AW)) ? (1 << AW) : len;
      m_words = 0;
      m_n     = 0;
   endtask

   // Called at posedge+1; pulses start for one cycle.
   task automatic do_start(input int len, input bit accepted);
      load_len = len[AW:0];
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      if (accepted) model_start(len);
   endtask

   // Called at posedge+1; offers one byte until the loader takes it.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_in    = b;
      while (!byte_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!byte_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got=0 want=1");
         byte_valid = 1'b0;
      end else begin
         m_buf[m_n] = b;
         m_n++;
         if (m_n == 4) begin
            if (m_words < m_limit) begin
               wr_t e;
               e.addr = m_words[AW-1:0];
               e.data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
               e.cyc  = cyc + 1;
               exp_q.push_back(e);
            end
            m_words++;
            m_n = 0;
         end
         @(posedge clk); #1;
         byte_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, done, 1'b1);
   endtask

   logic [7:0] prog_a [8];
   logic [7:0] prog_b [8];

   initial begin
      prog_a = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      prog_b = '{8'h6F, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};

      // Reset state
      #3;
      chk("rst_ready", byte_ready, 1'b0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, '0);
      chk("rst_wr_data", wr_data, '0);
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      #10 rst = 1'b0;
      @(posedge clk); #1;

      // 1: two words back-to-back
      do_start(2, 1'b1);
      chk("t1_stall_after_start", cpu_stall, 1'b1);
      chk("t1_ready_after_start", byte_ready, 1'b1);
      chk("t1_done_low", done, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(prog_a[i]);
      chk("t1_wr_en_in_write", wr_en, 1'b1);
      @(posedge clk); #1;
      chk("t1_done", done, 1'b1);
      chk("t1_stall_low", cpu_stall, 1'b0);
      chk("t1_err", err, 1'b0);
      chk("t1_nwr", nwr, 2);
      chk("t1_last_data", last_data, 32'h00100093);
      chk("t1_last_addr", last_addr, 2'd1);
      chk("t1_pending", exp_q.size(), 0);

      // 2: same load, valid toggled every other cycle
      nwr = 0;
      do_start(2, 1'b1);
      chk("t2_done_cleared", done, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send_byte(prog_a[i]);
         @(posedge clk); #1;
      end
      wait_done("t2_done");
      chk("t2_err", err, 1'b0);
      chk("t2_nwr", nwr, 2);
      chk("t2_last_data", last_data, 32'h00100093);
      chk("t2_pending", exp_q.size(), 0);

      // 3: timeout with a partial word
      nwr = 0;
      do_start(1, 1'b1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (TO - 1) @(posedge clk);
      #1;
      chk("t3_err_before_timeout", err, 1'b0);
      chk("t3_stall_before_timeout", cpu_stall, 1'b1);
      @(posedge clk); #1;
      chk("t3_err", err, 1'b1);
      chk("t3_done", done, 1'b1);
      chk("t3_stall_low", cpu_stall, 1'b0);
      chk("t3_nwr", nwr, 0);

      // 4: zero-length load
      do_start(0, 1'b0);
      chk("t4_done", done, 1'b1);
      chk("t4_err_cleared", err, 1'b0);
      chk("t4_stall", cpu_stall, 1'b0);
      chk("t4_ready", byte_ready, 1'b0);
      @(posedge clk); #1;
      chk("t4_stall_next", cpu_stall, 1'b0);
      chk("t4_nwr", nwr, 0);

      // 5: async reset after 5 of 8 bytes, then a clean reload
      do_start(2, 1'b1);
      for (int i = 0; i < 5; i++) send_byte(prog_a[i]);
      chk("t5_pending_before_rst", exp_q.size(), 0);
      chk("t5_stall_before_rst", cpu_stall, 1'b1);
      rst = 1'b1;
      #1;
      chk("t5_ready", byte_ready, 1'b0);
      chk("t5_wr_en", wr_en, 1'b0);
      chk("t5_wr_addr", wr_addr, '0);
      chk("t5_wr_data", wr_data, '0);
      chk("t5_stall", cpu_stall, 1'b0);
      chk("t5_done", done, 1'b0);
      chk("t5_err", err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      nwr = 0;
      do_start(2, 1'b1);
      for (int i = 0; i < 8; i++) send_byte(prog_b[i]);
      wait_done("t5_reload_done");
      chk("t5_nwr", nwr, 2);
      chk("t5_last_data", last_data, 32'h00A00513);
      chk("t5_last_addr", last_addr, 2'd1);
      chk("t5_pending", exp_q.size(), 0);

      // 6: over-length load (7 > depth 4) clamps; start mid-RECV ignored
      nwr = 0;
      do_start(7, 1'b1);
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(8'h10 + i));
         if (i == 5) begin
            do_start(1, 1'b0);
            chk("t6_stall_after_ignored_start", cpu_stall, 1'b1);
            chk("t6_done_after_ignored_start", done, 1'b0);
         end
      end
      wait_done("t6_done");
      chk("t6_nwr", nwr, 4);
      chk("t6_last_addr", last_addr, 2'd3);
      chk("t6_last_data", last_data, 32'h1F1E1D1C);
      chk("t6_pending", exp_q.size(), 0);
      chk("t6_ready_in_done", byte_ready, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
